// File: rtl/skinny_round_ctrl.sv
// Round sequencer for the Skinny-128 datapath: accepts a block, runs NR rounds
// with the 6-bit round-constant LFSR, then holds the result on an output handshake.
module skinny_round_ctrl #(
  parameter int NR = 48,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          dp_load,
  output logic          dp_en,
  output logic          tk_step,
  output logic [5:0]    rc,
  output logic [CW-1:0] round_idx,
  output logic          last_round,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(NR - 1);
  localparam logic [5:0]    RC_INIT  = 6'h01;

  state_t        state_reg, state_next;
  logic [CW-1:0] round_idx_reg, round_idx_next;
  logic [5:0]    rc_reg, rc_next;
  logic          out_valid_reg, out_valid_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      round_idx_reg <= '0;
      rc_reg        <= RC_INIT;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      round_idx_reg <= round_idx_next;
      rc_reg        <= rc_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    round_idx_next = round_idx_reg;
    rc_next        = rc_reg;
    out_valid_next = out_valid_reg;
    in_ready       = 1'b0;
    dp_load        = 1'b0;
    dp_en          = 1'b0;
    last_round     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dp_load        = 1'b1;
          state_next     = RUN;
          round_idx_next = '0;
          rc_next        = RC_INIT;
        end
      end
      RUN: begin
        dp_en = 1'b1;
        // Counter and constant freeze on the final round so DONE still shows them.
        if (round_idx_reg == LAST_IDX) begin
          last_round     = 1'b1;
          state_next     = DONE;
          out_valid_next = 1'b1;
        end else begin
          round_idx_next = round_idx_reg + CW'(1);
          rc_next        = {rc_reg[4:0], rc_reg[5] ^ rc_reg[4] ^ 1'b1};
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
          round_idx_next = '0;
          rc_next        = RC_INIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tk_step   = dp_en;
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign rc        = rc_reg;
  assign round_idx = round_idx_reg;

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Self-checking bench for skinny_round_ctrl: randomized gaps, backpressure and
// ignored inputs, checked against a cycle-offset model of one block's life.
module tb_skinny_round_ctrl;
  localparam int NR = 48;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          dp_load;
  logic          dp_en;
  logic          tk_step;
  logic [5:0]    rc;
  logic [CW-1:0] round_idx;
  logic          last_round;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_load = -1;

  skinny_round_ctrl #(.NR(NR), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .dp_load(dp_load),
    .dp_en(dp_en), .tk_step(tk_step), .rc(rc), .round_idx(round_idx),
    .last_round(last_round), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference round constant: 6-bit LFSR stepped n times from 1.
  function automatic int rc_ref(input int n);
    int r = 1;
    for (int i = 0; i < n; i++)
      r = ((r << 1) & 63) | (((r >> 5) ^ (r >> 4) ^ 1) & 1);
    return r;
  endfunction

  // Strobe invariants checked on every cycle.
  always @(negedge clk) begin
    checks++;
    if (dp_load && dp_en) begin
      errors++;
      $display("FAIL overlap: dp_load=%0b dp_en=%0b required not both 1", dp_load, dp_en);
    end
    checks++;
    if (tk_step !== dp_en) begin
      errors++;
      $display("FAIL tk_step: got %0b required %0b", tk_step, dp_en);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int gap, input int bp, input bit b2b, input int abort_round);
    int first9 [9] = '{'h01, 'h03, 'h07, 'h0F, 'h1F, 'h3E, 'h3D, 'h3B, 'h37};
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      out_ready = 1'($urandom % 2);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || dp_load !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle: in_ready=%0b busy=%0b dp_load=%0b out_valid=%0b required 1 0 0 0",
                 in_ready, busy, dp_load, out_valid);
      end
      next_cycle();
    end
    // accept cycle
    in_valid = 1'b1;
    out_ready = b2b ? 1'b1 : 1'($urandom % 2);
    @(negedge clk);
    checks++;
    if (dp_load !== 1'b1 || in_ready !== 1'b1 || dp_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL accept: dp_load=%0b in_ready=%0b dp_en=%0b busy=%0b required 1 1 0 0",
               dp_load, in_ready, dp_en, busy);
    end
    checks++;
    if (round_idx !== '0 || rc !== 6'h01) begin
      errors++;
      $display("FAIL accept_init: round_idx=%0d rc=%h required 0 01", round_idx, rc);
    end
    if (b2b && prev_load >= 0) begin
      checks++;
      if (cyc - prev_load != NR + 2) begin
        errors++;
        $display("FAIL period: load spacing %0d required %0d", cyc - prev_load, NR + 2);
      end
    end
    prev_load = cyc;
    next_cycle();
    // rounds
    for (int k = 0; k < NR; k++) begin
      in_valid = b2b ? 1'b1 : 1'($urandom % 2);
      out_ready = b2b ? 1'b1 : 1'($urandom % 2);
      if (k == abort_round) rst = 1'b1;
      @(negedge clk);
      checks++;
      if (dp_en !== 1'b1 || dp_load !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL run%0d: dp_en=%0b dp_load=%0b in_ready=%0b busy=%0b out_valid=%0b required 1 0 0 1 0",
                 k, dp_en, dp_load, in_ready, busy, out_valid);
      end
      checks++;
      if (round_idx !== CW'(k) || rc !== 6'(rc_ref(k))) begin
        errors++;
        $display("FAIL round%0d: round_idx=%0d rc=%h required %0d %h", k, round_idx, rc, k, rc_ref(k));
      end
      if (k < 9) begin
        checks++;
        if (rc !== 6'(first9[k])) begin
          errors++;
          $display("FAIL rc_table%0d: rc=%h required %h", k, rc, first9[k]);
        end
      end
      checks++;
      if (last_round !== (k == NR - 1)) begin
        errors++;
        $display("FAIL last_round%0d: got %0b required %0b", k, last_round, k == NR - 1);
      end
      next_cycle();
      if (k == abort_round) return;
    end
    // output backpressure; in_valid meanwhile must be ignored
    for (int b = 0; b < bp; b++) begin
      in_valid = 1'($urandom % 2);
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || dp_en !== 1'b0 || in_ready !== 1'b0 || dp_load !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold%0d: out_valid=%0b dp_en=%0b in_ready=%0b dp_load=%0b busy=%0b required 1 0 0 0 1",
                 b, out_valid, dp_en, in_ready, dp_load, busy);
      end
      checks++;
      if (round_idx !== CW'(NR - 1)) begin
        errors++;
        $display("FAIL hold_idx: round_idx=%0d required %0d", round_idx, NR - 1);
      end
      next_cycle();
    end
    // transfer cycle: an offered block must not be accepted here
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || dp_load !== 1'b0 || in_ready !== 1'b0 || last_round !== 1'b0) begin
      errors++;
      $display("FAIL transfer: out_valid=%0b dp_load=%0b in_ready=%0b last_round=%0b required 1 0 0 0",
               out_valid, dp_load, in_ready, last_round);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || rc !== 6'h01 || round_idx !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%0b busy=%0b out_valid=%0b rc=%h round_idx=%0d required 1 0 0 01 0",
               in_ready, busy, out_valid, rc, round_idx);
    end
    checks++;
    if (dp_load !== 1'b0 || dp_en !== 1'b0 || tk_step !== 1'b0 || last_round !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: dp_load=%0b dp_en=%0b tk_step=%0b last_round=%0b required 0 0 0 0",
               dp_load, dp_en, tk_step, last_round);
    end
    next_cycle();
  endtask

  task automatic test_single_block();
    run_block(3, 0, 1'b0, -1);
    run_block(0, 0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_block(2, 10, 1'b0, -1);
    for (int i = 0; i < 3; i++)
      run_block(int'($urandom_range(0, 4)), int'($urandom_range(0, 12)), 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    prev_load = -1;
    for (int i = 0; i < 4; i++) run_block(0, 0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_run();
    run_block(1, 0, 1'b0, 20);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || rc !== 6'h01 || round_idx !== '0 || out_valid !== 1'b0 || dp_en !== 1'b0) begin
      errors++;
      $display("FAIL abort: in_ready=%0b busy=%0b rc=%h round_idx=%0d out_valid=%0b dp_en=%0b required 1 0 01 0 0 0",
               in_ready, busy, rc, round_idx, out_valid, dp_en);
    end
    next_cycle();
    for (int i = 0; i < NR + 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet%0d: out_valid=%0b busy=%0b required 0 0", i, out_valid, busy);
      end
      next_cycle();
    end
    run_block(0, 2, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
